// File: rtl/reg_file_ctrl_pkg.sv
// Shared op codes and sequencer state encoding for the register-file controller.
package reg_file_ctrl_pkg;

  localparam int RF_DATA_WIDTH = 8;
  localparam int RF_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    OP_READ       = 2'b00,
    OP_WRITE      = 2'b01,
    OP_WRITE_PAIR = 2'b10,
    OP_READ_PAIR  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_READ     = 2'b01,
    ST_WRITE_LO = 2'b10,
    ST_WRITE_HI = 2'b11
  } state_t;

  function automatic logic op_is_pair(input op_t op);
    return (op == OP_WRITE_PAIR) || (op == OP_READ_PAIR);
  endfunction

  function automatic logic op_is_read(input op_t op);
    return (op == OP_READ) || (op == OP_READ_PAIR);
  endfunction

endpackage

// File: rtl/reg_file_ctrl.sv
// Request sequencer in front of the dual-port 32x8 register file SRAM.
// state       | meaning
// ST_IDLE     | ready for a request, ports quiet
// ST_READ     | both ports reading; data captured on the closing posedge
// ST_WRITE_LO | rd port writes low byte (or the single byte)
// ST_WRITE_HI | rd port writes high byte of a pair to base|1
module reg_file_ctrl
  import reg_file_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [ADDR_WIDTH-1:0]   req_rr,
  input  logic [ADDR_WIDTH-1:0]   req_rd,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic [DATA_WIDTH-1:0]   rsp_rd_data,
  output logic [DATA_WIDTH-1:0]   rsp_rr_data,
  output logic [ADDR_WIDTH-1:0]   rf_rr_addr,
  output logic [ADDR_WIDTH-1:0]   rf_rd_addr,
  output logic                    rf_rr_cs,
  output logic                    rf_rd_cs,
  output logic                    rf_rr_we,
  output logic                    rf_rd_we,
  output logic                    rf_rr_oe,
  output logic                    rf_rd_oe,
  inout  wire  [DATA_WIDTH-1:0]   rf_rr_data,
  inout  wire  [DATA_WIDTH-1:0]   rf_rd_data
);

  state_t                  state;
  op_t                     op_q;
  logic [ADDR_WIDTH-1:0]   rr_q;
  logic [ADDR_WIDTH-1:0]   rd_q;
  logic [2*DATA_WIDTH-1:0] wdata_q;

  logic [ADDR_WIDTH-1:0]   pair_lo;
  logic [ADDR_WIDTH-1:0]   pair_hi;
  logic                    pair_err;
  logic [DATA_WIDTH-1:0]   rd_drive;

  assign pair_lo  = {rd_q[ADDR_WIDTH-1:1], 1'b0};
  assign pair_hi  = {rd_q[ADDR_WIDTH-1:1], 1'b1};
  assign pair_err = op_is_pair(op_q) && rd_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rd_data <= '0;
      rsp_rr_data <= '0;
      op_q        <= OP_READ;
      rr_q        <= '0;
      rd_q        <= '0;
      wdata_q     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q      <= op_t'(req_op);
            rr_q      <= req_rr;
            rd_q      <= req_rd;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            state     <= op_is_read(op_t'(req_op)) ? ST_READ : ST_WRITE_LO;
          end
        end
        ST_READ: begin
          rsp_rd_data <= rf_rd_data;
          rsp_rr_data <= rf_rr_data;
          rsp_valid   <= 1'b1;
          rsp_err     <= pair_err;
          req_ready   <= 1'b1;
          state       <= ST_IDLE;
        end
        ST_WRITE_LO: begin
          if (op_q == OP_WRITE_PAIR) begin
            state <= ST_WRITE_HI;
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= pair_err;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_WRITE_HI: begin
          rsp_valid <= 1'b1;
          rsp_err   <= pair_err;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Pin decode is purely from state, so an async reset drops cs/we at once.
  always_comb begin
    rf_rr_cs   = 1'b0;
    rf_rd_cs   = 1'b0;
    rf_rd_we   = 1'b0;
    rf_rr_oe   = 1'b0;
    rf_rd_oe   = 1'b0;
    rf_rr_addr = '0;
    rf_rd_addr = '0;
    rd_drive   = '0;
    case (state)
      ST_READ: begin
        rf_rr_cs   = 1'b1;
        rf_rd_cs   = 1'b1;
        rf_rr_oe   = 1'b1;
        rf_rd_oe   = 1'b1;
        rf_rr_addr = (op_q == OP_READ) ? rr_q : pair_hi;
        rf_rd_addr = (op_q == OP_READ) ? rd_q : pair_lo;
      end
      ST_WRITE_LO: begin
        rf_rd_cs   = 1'b1;
        rf_rd_we   = 1'b1;
        rf_rd_addr = (op_q == OP_WRITE) ? rd_q : pair_lo;
        rd_drive   = wdata_q[DATA_WIDTH-1:0];
      end
      ST_WRITE_HI: begin
        rf_rd_cs   = 1'b1;
        rf_rd_we   = 1'b1;
        rf_rd_addr = pair_hi;
        rd_drive   = wdata_q[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      default: ;
    endcase
  end

  // The rr port never writes, keeping the SRAM's rr-over-rd priority unused.
  assign rf_rr_we   = 1'b0;
  assign rf_rr_data = rf_rr_we ? {DATA_WIDTH{1'b0}} : {DATA_WIDTH{1'bz}};
  assign rf_rd_data = rf_rd_we ? rd_drive : {DATA_WIDTH{1'bz}};

endmodule
